// File: rtl/pwm_decoder_if.sv
// PWM decoder signal bundle: the raw PWM input plus the measurement results.
// The master side (the environment) drives pwm_in and observes the results;
// the slave side (the decoder) samples pwm_in and drives the results.
interface pwm_decoder_if #(
  parameter int CNT_W = 16
);
  logic             pwm_in;
  logic [7:0]       duty_cycle;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] period;
  logic             valid;
  logic             stuck;

  modport master (
    output pwm_in,
    input  duty_cycle, high_time, period, valid, stuck
  );

  modport slave (
    input  pwm_in,
    output duty_cycle, high_time, period, valid, stuck
  );
endinterface

// File: rtl/pwm_decoder.sv
// PWM decoder: measures high time and rise-to-rise period of an asynchronous
// PWM input in clk_in cycles, reports a clamped duty value, and flags a
// stuck input once no edge has been seen for TIMEOUT cycles.
// The interface instance must be built with the same CNT_W as this module.
module pwm_decoder #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk_in,
  input  logic         rst_in,
  pwm_decoder_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_RISE,
    HIGH,
    LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] DUTY_MAX = CNT_W'(255);

  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_done_q;
  logic [CNT_W-1:0] high_q;
  state_t           state_q;

  logic [7:0]       duty_q;
  logic [CNT_W-1:0] high_time_q;
  logic [CNT_W-1:0] period_q;
  logic             valid_q;
  logic             stuck_q;

  logic             rise;
  logic             fall;
  logic             timeout;

  // Edge detection on the synchronized level against its one-cycle history.
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

  // Timeout fires once per edge-free interval; a coincident rise wins, and
  // to_done_q keeps a counter saturated exactly at TIMEOUT from re-firing.
  assign timeout = (cnt_q == TO_VAL) && !rise && !to_done_q;

  // Counter next value: restart at 1 on a rise, otherwise count up and stick at max.
  always_comb begin
    cnt_d = cnt_q;
    if (rise) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Two-flop synchronizer followed by the history flop used for edge detection.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Cycle counter since the last rise, plus the timeout-already-reported flag.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q     <= '0;
      to_done_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (rise) begin
        to_done_q <= 1'b0;
      end else if (timeout) begin
        to_done_q <= 1'b1;
      end
    end
  end

  // Measurement FSM with registered result outputs; timeout overrides any state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= WAIT_RISE;
      high_q      <= '0;
      duty_q      <= 8'h00;
      high_time_q <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      stuck_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (timeout) begin
        state_q     <= WAIT_RISE;
        high_time_q <= '0;
        period_q    <= '0;
        duty_q      <= s2_q ? 8'hFF : 8'h00;
        stuck_q     <= 1'b1;
        valid_q     <= 1'b1;
      end else begin
        case (state_q)
          WAIT_RISE: begin
            // First rise only opens a period; nothing complete to report yet.
            if (rise) begin
              state_q <= HIGH;
            end
          end
          HIGH: begin
            if (fall) begin
              high_q  <= cnt_q;
              state_q <= LOW;
            end
          end
          LOW: begin
            if (rise) begin
              high_time_q <= high_q;
              period_q    <= cnt_q;
              duty_q      <= (high_q > DUTY_MAX) ? 8'hFF : high_q[7:0];
              stuck_q     <= 1'b0;
              valid_q     <= 1'b1;
              state_q     <= HIGH;
            end
          end
          default: begin
            state_q <= WAIT_RISE;
          end
        endcase
      end
    end
  end

  assign bus.duty_cycle = duty_q;
  assign bus.high_time  = high_time_q;
  assign bus.period     = period_q;
  assign bus.valid      = valid_q;
  assign bus.stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Testbench for pwm_decoder: directed waveforms for the documented scenarios
// plus randomized periods, glitches and stuck intervals, compared every cycle
// against an event-level reference model built from the sampled input history.
module tb_pwm_decoder;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1024;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  pwm_decoder_if #(.CNT_W(CNT_W)) bus_if ();

  pwm_decoder #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus_if)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  // Sampled pwm_in value at every clock edge, indexed by edge number.
  bit samp[$];
  int edge_no       = 0;
  int last_rst_edge = -1;

  // Reference model state: times (edge numbers) of the events seen so far.
  bit m_have_rise, m_have_fall, m_fired;
  int m_rise_e, m_fall_e, m_ref_e;

  // Expected outputs after the current edge.
  bit              e_valid, e_stuck;
  int unsigned     e_duty, e_high, e_period;

  // Values captured from the DUT at its most recent valid pulse.
  int n_valid         = 0;
  int last_valid_edge = 0;
  int unsigned cap_duty, cap_high, cap_period;
  bit cap_stuck;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_no);
    end
  endtask

  // Synchronizer output value seen at edge i; reset forces the pipeline to 0.
  function automatic bit x_at(input int i);
    if (i < 0 || i <= last_rst_edge) return 1'b0;
    return samp[i];
  endfunction

  // Reference model: a pwm_in rise sampled at edge k is acted on at edge k+2.
  function automatic void model_edge(input bit r);
    int  e = edge_no;
    bit  rs, fl;
    int  elapsed;
    e_valid = 1'b0;
    if (r) begin
      e_duty = 0; e_high = 0; e_period = 0; e_stuck = 1'b0;
      m_have_rise = 1'b0; m_have_fall = 1'b0; m_fired = 1'b0;
      m_ref_e = e + 1;
      last_rst_edge = e;
      return;
    end
    rs      = x_at(e - 2) && !x_at(e - 3);
    fl      = !x_at(e - 2) && x_at(e - 3);
    elapsed = e - m_ref_e;
    if (rs) begin
      if (m_have_rise && m_have_fall) begin
        e_high   = m_fall_e - m_rise_e;
        e_period = e - m_rise_e;
        e_duty   = (e_high > 255) ? 255 : e_high;
        e_stuck  = 1'b0;
        e_valid  = 1'b1;
      end
      m_have_rise = 1'b1; m_have_fall = 1'b0; m_fired = 1'b0;
      m_rise_e = e; m_ref_e = e;
    end else if (elapsed == TIMEOUT && !m_fired) begin
      e_high = 0; e_period = 0;
      e_duty = x_at(e - 2) ? 255 : 0;
      e_stuck = 1'b1; e_valid = 1'b1;
      m_fired = 1'b1; m_have_rise = 1'b0; m_have_fall = 1'b0;
    end else if (fl && m_have_rise) begin
      m_fall_e = e; m_have_fall = 1'b1;
    end
  endfunction

  // One clock cycle: drive inputs (optionally a sub-cycle glitch), step the
  // model at the edge, then compare every output just after the edge.
  task automatic step(input bit p, input bit r, input bit glitch = 1'b0);
    bus_if.pwm_in = p;
    rst_in        = r;
    if (glitch) begin
      bus_if.pwm_in = ~p;
      #2;
      bus_if.pwm_in = p;
    end
    @(posedge clk_in);
    samp.push_back(p);
    model_edge(r);
    edge_no++;
    #1;
    check_val("valid", bus_if.valid, e_valid);
    check_val("duty_cycle", bus_if.duty_cycle, e_duty);
    check_val("high_time", bus_if.high_time, e_high);
    check_val("period", bus_if.period, e_period);
    check_val("stuck", bus_if.stuck, e_stuck);
    if (bus_if.valid) begin
      n_valid++;
      last_valid_edge = edge_no;
      cap_duty   = bus_if.duty_cycle;
      cap_high   = bus_if.high_time;
      cap_period = bus_if.period;
      cap_stuck  = bus_if.stuck;
      $display("valid @edge %0d: high_time=%0d period=%0d duty_cycle=%0d stuck=%0d",
               edge_no, cap_high, cap_period, cap_duty, cap_stuck);
    end
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) step(v, 1'b0);
  endtask

  // n periods of a high-first waveform.
  task automatic gen(input int hi, input int per, input int n);
    for (int k = 0; k < n; k++) begin
      hold(1'b1, hi);
      hold(1'b0, per - hi);
    end
  endtask

  task automatic check_cap(input string tag, input int unsigned hi, input int unsigned per,
                           input int unsigned duty, input bit stk);
    check_val({tag, "_high"}, cap_high, hi);
    check_val({tag, "_period"}, cap_period, per);
    check_val({tag, "_duty"}, cap_duty, duty);
    check_val({tag, "_stuck"}, cap_stuck, stk);
  endtask

  initial begin
    int v0, t0, hi, lo;
    bus_if.pwm_in = 1'b0;

    // Reset state.
    repeat (3) step(1'b0, 1'b1);
    check_val("rst_valid", bus_if.valid, 0);
    check_val("rst_duty", bus_if.duty_cycle, 0);
    check_val("rst_stuck", bus_if.stuck, 0);
    hold(1'b0, 5);

    // 128/256 for three periods: two complete periods reported.
    v0 = n_valid;
    gen(128, 256, 3);
    check_val("p128_count", n_valid - v0, 2);
    check_cap("p128", 128, 256, 128, 1'b0);

    // Held low: one timeout report, TIMEOUT cycles after the last rise.
    t0 = last_valid_edge;
    v0 = n_valid;
    hold(1'b0, 2000);
    check_val("low_count", n_valid - v0, 1);
    check_val("low_delay", last_valid_edge - t0, TIMEOUT);
    check_cap("low", 0, 0, 0, 1'b1);

    // Near-full and minimal duty.
    gen(255, 256, 3);
    check_cap("p255", 255, 256, 255, 1'b0);
    gen(1, 256, 3);
    check_cap("p1", 1, 256, 1, 1'b0);

    // Held high: one timeout report with full duty.
    hold(1'b1, 3);
    v0 = n_valid;
    hold(1'b1, 2000);
    check_val("high_count", n_valid - v0, 1);
    check_cap("high", 0, 0, 255, 1'b1);

    // Restart: first rise reports nothing, stuck clears at the second rise.
    hold(1'b0, 10);
    v0 = n_valid;
    gen(128, 256, 1);
    check_val("restart1_count", n_valid - v0, 0);
    check_val("restart1_stuck", bus_if.stuck, 1);
    gen(128, 256, 1);
    check_val("restart2_count", n_valid - v0, 1);
    check_cap("restart2", 128, 256, 128, 1'b0);

    // Long period: duty saturates.
    gen(400, 600, 3);
    check_cap("p400", 400, 600, 255, 1'b0);

    // Sub-cycle glitches during the low phase are never sampled.
    v0 = n_valid;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1);
    check_val("glitch_count", n_valid - v0, 0);

    // Reset mid-period (low phase of a low-first 128/256 waveform).
    hold(1'b0, 128 - 20);
    gen(128, 256, 1);
    hold(1'b0, 50);
    step(1'b0, 1'b1);
    check_val("midrst_duty", bus_if.duty_cycle, 0);
    check_val("midrst_high", bus_if.high_time, 0);
    check_val("midrst_period", bus_if.period, 0);
    check_val("midrst_stuck", bus_if.stuck, 0);
    v0 = n_valid;
    hold(1'b0, 78);
    gen(128, 256, 1);
    check_val("midrst1_count", n_valid - v0, 0);
    gen(128, 256, 1);
    check_val("midrst2_count", n_valid - v0, 1);
    check_cap("midrst", 128, 256, 128, 1'b0);

    // Randomized periods with occasional glitches and stuck-low intervals.
    for (int k = 0; k < 30; k++) begin
      hi = $urandom_range(1, 300);
      lo = ($urandom_range(0, 7) == 0) ? $urandom_range(1100, 1300) : $urandom_range(1, 300);
      hold(1'b1, hi);
      for (int i = 0; i < lo; i++) step(1'b0, 1'b0, ($urandom_range(0, 15) == 0));
    end
    hold(1'b0, 5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of the cycle counter and of the high_time/period outputs; legal range 9..32.
REQ-002 Parameter TIMEOUT, default 1024, SHALL set the cycle count without a pwm_in edge after which the input is declared stuck; legal range 2..2^CNT_W-1.
REQ-003 clk_in  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_in  input  1  SHALL be a synchronous, active-high reset.
REQ-005 pwm_in  input  1  SHALL be the asynchronous PWM waveform to measure.
REQ-006 duty_cycle  output  8  SHALL be the measured duty in 0-255 units, where 256 cycles equals one full period.
REQ-007 high_time  output  CNT_W  SHALL be the measured high duration of the last complete period, in clk_in cycles.
REQ-008 period  output  CNT_W  SHALL be the measured rise-to-rise duration of the last complete period, in clk_in cycles.
REQ-009 valid  output  1  SHALL be a one-cycle pulse when the outputs above are updated.
REQ-010 stuck  output  1  SHALL be a level that is high while the last update was a timeout.

Function
REQ-011 pwm_in SHALL pass through a 2-flop synchronizer (s1, s2) and then a history flop (s3); rise = s2 & ~s3; fall = ~s2 & s3.
REQ-012 Counter cnt SHALL load 1 on a clock edge where rise is true, otherwise increment, and saturate at 2^CNT_W-1 without wrapping.
REQ-013 FSM states SHALL be WAIT_RISE, HIGH and LOW; reset state is WAIT_RISE.
REQ-014 WAIT_RISE: on rise, go to HIGH with no output update, because no full period has been seen.
REQ-015 HIGH: on fall, latch high_reg <= cnt and go to LOW.
REQ-016 LOW: on rise, publish and go to HIGH.
  - Publish: high_time <= high_reg, period <= cnt, duty_cycle <= min(high_reg, 255), valid <= 1, stuck <= 0.
REQ-017 Timeout: in any state, on the edge where cnt == TIMEOUT and no rise occurs, the block SHALL go to WAIT_RISE and update the outputs as follows:
  - high_time <= 0, period <= 0
  - duty_cycle <= s2 ? 255 : 0
  - stuck <= 1, valid <= 1
REQ-018 Timeout SHALL fire at most once per stuck interval; the saturating cnt does not re-trigger it. The first rise afterwards behaves as in REQ-014.
REQ-019 If rise and cnt == TIMEOUT coincide, rise SHALL take priority and timeout SHALL be suppressed.
REQ-020 Latency: a pwm_in rising edge sampled at clock edge k SHALL produce valid high after clock edge k+2, provided the FSM is in LOW.
REQ-021 duty_cycle, high_time, period and stuck SHALL hold their values between valid pulses.
REQ-022 A pulse shorter than one cycle that the synchronizer does not capture SHALL be ignored.
REQ-023 high_time > period SHALL never be reported for a monotonic input.

Reset
REQ-024 While rst_in is high at a clock edge, the block SHALL set:
  - s1, s2, s3 <= 0
  - cnt <= 0, high_reg <= 0
  - state <= WAIT_RISE
  - duty_cycle, high_time, period <= 0
  - valid <= 0, stuck <= 0
REQ-025 Reset asserted mid-period SHALL discard the partial measurement; the first valid after release requires two observed rises.
REQ-026 No output SHALL change between reset release and the first publish or timeout.

Verification
REQ-027 256-cycle PWM, high 128 cycles, run 3 periods -> valid exactly twice, each time high_time=128, period=256, duty_cycle=128, stuck=0.
REQ-028 256-cycle PWM, high 255 cycles -> duty_cycle=255, high_time=255, period=256; high 1 cycle -> duty_cycle=1, high_time=1.
REQ-029 pwm_in held at 0 for 2000 cycles after a period has been measured -> exactly one valid pulse, TIMEOUT cycles after the last rise; duty_cycle=0, stuck=1, high_time=period=0.
REQ-030 pwm_in held at 1 for 2000 cycles -> one valid pulse, duty_cycle=255, stuck=1; on restart the stuck flag clears on the second rise.
REQ-031 Period of 600 cycles with high 400 -> high_time=400, period=600, duty_cycle=255 (saturated).
REQ-032 rst_in pulsed at cycle 50 of a 128/256 waveform -> all outputs 0; the next valid arrives at the second rise after release with the correct values.
